// File: rtl/pipelined_addsub.sv
// pipelined_addsub: segmented-carry pipelined adder/subtractor with valid/ready
// back-pressure and carry/overflow/zero flags. Defining ADDSUB_SATURATE_EN
// clamps signed-overflowing results to the signed extreme.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);
    localparam int SEG = WIDTH / STAGES;
    localparam int L   = STAGES - 1;

    logic             adv, acc, ovf, ovf_q, zero_q;
    logic [WIDTH-1:0] raw, fin;
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] r_q [STAGES];
    logic [WIDTH-1:0] a_s [STAGES];
    logic [WIDTH-1:0] b_s [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic [WIDTH-1:0] r_n [STAGES];
    logic             v_q [STAGES];
    logic             c_q [STAGES];
    logic             v_s [STAGES];
    logic             c_s [STAGES];
    logic             c_n [STAGES];

    // the whole pipe moves together, so one stalled output freezes every stage
    assign adv      = !v_q[L] || out_ready;
    assign in_ready = adv && rst_n;
    assign acc      = in_valid && in_ready;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            logic [SEG:0]     sum;
            logic [WIDTH-1:0] r_tmp;
            if (k == 0) begin : g_head
                assign a_s[k] = in1;
                assign b_s[k] = sub ? ~in2 : in2;
                assign c_s[k] = sub;
                assign r_s[k] = '0;
                assign v_s[k] = acc;
            end else begin : g_body
                assign a_s[k] = a_q[k-1];
                assign b_s[k] = b_q[k-1];
                assign c_s[k] = c_q[k-1];
                assign r_s[k] = r_q[k-1];
                assign v_s[k] = v_q[k-1];
            end
            assign sum = {1'b0, a_s[k][k*SEG +: SEG]} + {1'b0, b_s[k][k*SEG +: SEG]}
                       + {{SEG{1'b0}}, c_s[k]};
            // splice this stage's segment into the partial result
            always_comb begin
                r_tmp                = r_s[k];
                r_tmp[k*SEG +: SEG] = sum[SEG-1:0];
            end
            assign r_n[k] = r_tmp;
            assign c_n[k] = sum[SEG];
        end
    endgenerate

    assign raw = r_n[L];
    assign ovf = (a_s[L][WIDTH-1] == b_s[L][WIDTH-1]) && (raw[WIDTH-1] != a_s[L][WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
    assign fin = ovf ? {a_s[L][WIDTH-1], {(WIDTH-1){!a_s[L][WIDTH-1]}}} : raw;
`else
    assign fin = raw;
`endif

    // shift every stage (bubbles included) on advance; last stage holds the output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                v_q[i] <= 1'b0;
                c_q[i] <= 1'b0;
                a_q[i] <= '0;
                b_q[i] <= '0;
                r_q[i] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                v_q[i] <= v_s[i];
                c_q[i] <= c_n[i];
                a_q[i] <= a_s[i];
                b_q[i] <= b_s[i];
                r_q[i] <= (i == L) ? fin : r_n[i];
            end
            ovf_q  <= ovf;
            zero_q <= (fin == '0);
        end
    end

    assign out_valid = v_q[L];
    assign out       = r_q[L];
    assign carry     = c_q[L];
    assign overflow  = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed and randomized checks of pipelined_addsub against an arithmetic reference model
module tb_pipelined_addsub;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
    logic [31:0] in1 = '0, in2 = '0;
    logic        ir2, ov2, c2, f2, z2, ir4, ov4, c4, f4, z4, ir1, ov1, c1, f1, z1;
    logic [31:0] o2, o4, o1;

    pipelined_addsub #(.WIDTH(32), .STAGES(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(ir2), .in1(in1), .in2(in2), .sub(sub), .out_valid(ov2), .out_ready(out_ready),
        .out(o2), .carry(c2), .overflow(f2), .zero(z2));
    pipelined_addsub #(.WIDTH(32), .STAGES(4)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(ir4), .in1(in1), .in2(in2), .sub(sub), .out_valid(ov4), .out_ready(out_ready),
        .out(o4), .carry(c4), .overflow(f4), .zero(z4));
    pipelined_addsub #(.WIDTH(32), .STAGES(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(ir1), .in1(in1), .in2(in2), .sub(sub), .out_valid(ov1), .out_ready(out_ready),
        .out(o1), .carry(c1), .overflow(f1), .zero(z1));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    exp_t        q[$];
    int          total = 0, bad = 0, popped = 0;
    logic        accepted = 1'b0, hold_v = 1'b0;
    logic [31:0] hold = '0;

    // reference: plain integer arithmetic on the operands
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint sr;
        sr  = s ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
        e.o = (sr > 64'sh7FFFFFFF) || (sr < -64'sh80000000);
        e.c = s ? (a >= b) : (({1'b0, a} + {1'b0, b}) > 33'h0FFFFFFFF);
        e.r = s ? a - b : a + b;
`ifdef ADDSUB_SATURATE_EN
        if (e.o) e.r = (sr > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
        e.z = (e.r == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // one clock: scoreboard the output handshake, record the input handshake
    task automatic cyc();
        exp_t e;
        #1;
        if (hold_v && rst_n) begin
            chk("hold_valid", {31'b0, ov2}, 1);
            chk("hold_out", o2, hold);
        end
        hold_v = ov2 && !out_ready;
        hold   = o2;
        if (ov2 && !out_ready) chk("in_ready_stall", {31'b0, ir2}, 0);
        if (ov2 && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", {31'b0, ov2}, 0);
            else begin
                e = q.pop_front();
                popped++;
                chk("sb_out", o2, e.r);
                chk("sb_carry", {31'b0, c2}, {31'b0, e.c});
                chk("sb_ovf", {31'b0, f2}, {31'b0, e.o});
                chk("sb_zero", {31'b0, z2}, {31'b0, e.z});
            end
        end
        accepted = in_valid && ir2;
        if (accepted) q.push_back(model(in1, in2, sub));
        if (!rst_n) begin
            q.delete();
            hold_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] er, input logic ec, input logic eo, input logic ez);
        in1 = a; in2 = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        chk("accept", {31'b0, accepted}, 1);
        in_valid = 1'b0;
        chk("lat_early", {31'b0, ov2}, 0);
        cyc();
        chk("lat_valid", {31'b0, ov2}, 1);
        chk("dir_out", o2, er);
        chk("dir_carry", {31'b0, c2}, {31'b0, ec});
        chk("dir_ovf", {31'b0, f2}, {31'b0, eo});
        chk("dir_zero", {31'b0, z2}, {31'b0, ez});
        cyc();
    endtask

    initial begin
        int k, start;
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", {31'b0, ov2}, 0);
        chk("rst_out", o2, 0);
        chk("rst_flags", {29'b0, c2, f2, z2}, 0);
        chk("rst_ready", {31'b0, ir2}, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", {30'b0, ir4, ir1}, 3);
        in1 = 32'h0000FFFF; in2 = 32'h1; sub = 1'b0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("s1_valid", {31'b0, ov1}, {31'b0, i == 1});
            chk("s4_valid", {31'b0, ov4}, {31'b0, i == 4});
            if (i == 1) chk("s1_out", o1, 32'h00010000);
            if (i == 4) begin
                chk("s4_out", o4, 32'h00010000);
                chk("s4_flags", {29'b0, c4, f4, z4}, 0);
            end
            cyc();
        end
        beat(32'd2, 32'd20, 1'b0, 32'd22, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SATURATE_EN
        beat(32'h7FFFFFFF, 32'd1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
`else
        beat(32'h7FFFFFFF, 32'd1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
`endif
        beat(32'd5, 32'd5, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1);
        beat(32'd3, 32'd5, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        beat(32'hFFFFFFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
        k = 0;
        start = popped;
        for (int t = 0; t < 40 && (k < 8 || q.size() > 0); t++) begin
            in_valid = (k < 8); in1 = 32'(k); in2 = 32'(k); sub = 1'b0;
            out_ready = !(t >= 4 && t <= 6);
            cyc();
            if (accepted) k++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_cnt", 32'(popped - start), 8);
        in1 = 32'd25; in2 = 32'd5; sub = 1'b0; in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("no_stale_out", {31'b0, ov2}, 0);
            cyc();
        end
        beat(32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 300; t++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sub = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: in1 = 32'h7FFFFFFF;
                1: in1 = 32'h80000000;
                default: in1 = $urandom;
            endcase
            in2 = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int t = 0; t < 10 && q.size() > 0; t++) cyc();
        chk("drain", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
